mux2x1_arb: RTL and testbench

Two-requester round-robin arbiter that owns the select line of a registered 2:1 datapath mux. It shares one downstream stream between two upstream packet sources using valid/ready handshakes, holds the grant for a whole packet, and alternates priority between sources. It sits between two producers and one consumer wherever the team's 2:1 mux is shared.

---
 rtl/mux2x1_arb_if.sv | 49 ++++
 rtl/mux2x1_arb.sv | 184 ++++++++++++++++++
 tb/tb_mux2x1_arb.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux2x1_arb_if.sv
// mux2x1_arb_if: bundle of the two upstream streams, the downstream stream
// and the grant vector for the mux2x1_arb round-robin arbiter.
//   i0_* / i1_*   : upstream sources (valid, data, last in; ready out of the arbiter)
//   y_*           : downstream stream (valid, data, last, src out; ready in)
//   gnt           : one-hot current grant, 00 while idle
// Modports:
//   slave  - arbiter view (consumes i0/i1, produces y and gnt)
//   master - environment view (drives sources and downstream ready)
interface mux2x1_arb_if #(
  parameter int WIDTH = 8
);
  logic             i0_valid;
  logic [WIDTH-1:0] i0_data;
  logic             i0_last;
  logic             i0_ready;

  logic             i1_valid;
  logic [WIDTH-1:0] i1_data;
  logic             i1_last;
  logic             i1_ready;

  logic             y_valid;
  logic [WIDTH-1:0] y_data;
  logic             y_last;
  logic             y_src;
  logic             y_ready;

  logic [1:0]       gnt;

  modport slave (
    input  i0_valid, i0_data, i0_last,
    output i0_ready,
    input  i1_valid, i1_data, i1_last,
    output i1_ready,
    output y_valid, y_data, y_last, y_src,
    input  y_ready,
    output gnt
  );

  modport master (
    output i0_valid, i0_data, i0_last,
    input  i0_ready,
    output i1_valid, i1_data, i1_last,
    input  i1_ready,
    input  y_valid, y_data, y_last, y_src,
    output y_ready,
    input  gnt
  );
endinterface

// File: rtl/mux2x1_arb.sv
// mux2x1_arb: two-requester round-robin packet arbiter driving the select of
// a registered 2:1 datapath mux. The grant is held for a whole packet and
// priority alternates after every release.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - mux2x1_arb_if.slave: i0_*/i1_* sources, y_* registered output,
//          gnt one-hot grant
// Parameters:
//   WIDTH     - data width
//   MAX_BEATS - burst cap (1..255), only used with MUX2X1_ARB_BURST_LIMIT_EN
// Optional feature macro: MUX2X1_ARB_BURST_LIMIT_EN
//   defined   - a grant is also released after MAX_BEATS accepted beats
//   undefined - a grant is released only on an accepted last beat
module mux2x1_arb #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 4
) (
  input logic          clk,
  input logic          rst,
  mux2x1_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_e;

  // Reject an out-of-range burst cap at elaboration time.
  if ((MAX_BEATS < 1) || (MAX_BEATS > 255)) begin : g_bad_max_beats
    $error("mux2x1_arb: MAX_BEATS must be in 1..255");
  end

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             y_valid_q, y_valid_d;
  logic [WIDTH-1:0] y_data_q, y_data_d;
  logic             y_last_q, y_last_d;
  logic             y_src_q, y_src_d;

  logic             sel_s;
  logic             out_free_s;
  logic             mux_valid_s;
  logic [WIDTH-1:0] mux_data_s;
  logic             mux_last_s;
  logic             mux_ready_s;
  logic             acc_s;
  logic             release_s;
  logic             burst_done_s;
  logic             i0_ready_s;
  logic             i1_ready_s;
  logic [1:0]       gnt_s;

  // Select line of the datapath mux equals the granted index.
  assign sel_s       = (state_q == GRANT1);
  // The output register can take a beat when empty or being drained this cycle.
  assign out_free_s  = ~y_valid_q | bus.y_ready;
  assign mux_valid_s = sel_s ? bus.i1_valid : bus.i0_valid;
  assign mux_data_s  = sel_s ? bus.i1_data  : bus.i0_data;
  assign mux_last_s  = sel_s ? bus.i1_last  : bus.i0_last;
  assign mux_ready_s = sel_s ? i1_ready_s   : i0_ready_s;
  assign acc_s       = mux_valid_s & mux_ready_s;
  assign release_s   = acc_s & (mux_last_s | burst_done_s);

`ifdef MUX2X1_ARB_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  // Beats accepted in the current grant; the beat that meets the cap releases.
  assign burst_done_s = (beat_cnt_q == CNT_LAST);

  // Beat counter next value: clear on release, count on accept.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (release_s) begin
      beat_cnt_d = {CNT_W{1'b0}};
    end else if (acc_s) begin
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
  end

  // Beat counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= {CNT_W{1'b0}};
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end
`else
  assign burst_done_s = 1'b0;
`endif

  // Next-state, grant/ready decode and output register next values.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    y_valid_d  = y_valid_q;
    y_data_d   = y_data_q;
    y_last_d   = y_last_q;
    y_src_d    = y_src_q;
    i0_ready_s = 1'b0;
    i1_ready_s = 1'b0;
    gnt_s      = 2'b00;

    case (state_q)
      IDLE: begin
        if (bus.i0_valid && bus.i1_valid) begin
          state_d = prio_q ? GRANT1 : GRANT0;
        end else if (bus.i0_valid) begin
          state_d = GRANT0;
        end else if (bus.i1_valid) begin
          state_d = GRANT1;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT0: begin
        gnt_s      = 2'b01;
        i0_ready_s = out_free_s;
      end
      GRANT1: begin
        gnt_s      = 2'b10;
        i1_ready_s = out_free_s;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Output register: load on accept, drain when consumed, otherwise hold.
    if (acc_s) begin
      y_valid_d = 1'b1;
      y_data_d  = mux_data_s;
      y_last_d  = mux_last_s;
      y_src_d   = sel_s;
    end else if (bus.y_ready) begin
      y_valid_d = 1'b0;
    end else begin
      y_valid_d = y_valid_q;
    end

    // Release goes back through IDLE, so consecutive packets have one gap cycle.
    if (release_s) begin
      state_d = IDLE;
      prio_d  = ~sel_s;
    end else begin
      prio_d  = prio_q;
    end
  end

  // State, priority and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      y_valid_q <= 1'b0;
      y_data_q  <= {WIDTH{1'b0}};
      y_last_q  <= 1'b0;
      y_src_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      y_last_q  <= y_last_d;
      y_src_q   <= y_src_d;
    end
  end

  assign bus.i0_ready = i0_ready_s;
  assign bus.i1_ready = i1_ready_s;
  assign bus.gnt      = gnt_s;
  assign bus.y_valid  = y_valid_q;
  assign bus.y_data   = y_data_q;
  assign bus.y_last   = y_last_q;
  assign bus.y_src    = y_src_q;

endmodule

// File: tb/tb_mux2x1_arb.sv
// tb_mux2x1_arb: directed self-checking bench for mux2x1_arb.
module tb_mux2x1_arb;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mux2x1_arb_if #(.WIDTH(WIDTH)) bus ();

  mux2x1_arb #(.WIDTH(WIDTH), .MAX_BEATS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Source queues and run logs.
  logic [7:0] q0d[$];
  bit         q0l[$];
  logic [7:0] q1d[$];
  bit         q1l[$];
  logic [7:0] od[$];
  bit         ol[$];
  bit         os[$];
  int         ot[$];
  logic [7:0] lyd[$];
  bit         lyv[$];
  bit         lyl[$];
  bit         lys[$];
  bit         lr0[$];
  logic [1:0] lg[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i0_valid = 1'b0; bus.i0_data = 8'h00; bus.i0_last = 1'b0;
    bus.i1_valid = 1'b0; bus.i1_data = 8'h00; bus.i1_last = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    bus.y_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Drives both sources from their queues and logs the outputs each cycle.
  task automatic run(input int max_cyc, input int ys_from, input int ys_len,
                     input int s1_from, input int s1_len, input int i0_from,
                     output bit done);
    bit hs0, hs1;
    done = 1'b0;
    od.delete(); ol.delete(); os.delete(); ot.delete();
    lyd.delete(); lyv.delete(); lyl.delete(); lys.delete(); lr0.delete(); lg.delete();
    for (int c = 0; c < max_cyc && !done; c++) begin
      bus.y_ready = (c >= ys_from && c < ys_from + ys_len) ? 1'b0 : 1'b1;
      if (q0d.size() > 0 && c >= i0_from) begin
        bus.i0_valid = 1'b1; bus.i0_data = q0d[0]; bus.i0_last = q0l[0];
      end else begin
        bus.i0_valid = 1'b0; bus.i0_data = 8'h00; bus.i0_last = 1'b0;
      end
      if (q1d.size() > 0 && !(c >= s1_from && c < s1_from + s1_len)) begin
        bus.i1_valid = 1'b1; bus.i1_data = q1d[0]; bus.i1_last = q1l[0];
      end else begin
        bus.i1_valid = 1'b0; bus.i1_data = 8'h00; bus.i1_last = 1'b0;
      end
      @(negedge clk);
      lyv.push_back(bus.y_valid); lyd.push_back(bus.y_data);
      lyl.push_back(bus.y_last);  lys.push_back(bus.y_src);
      lr0.push_back(bus.i0_ready); lg.push_back(bus.gnt);
      hs0 = bus.i0_valid && bus.i0_ready;
      hs1 = bus.i1_valid && bus.i1_ready;
      if (bus.y_valid && bus.y_ready) begin
        od.push_back(bus.y_data); ol.push_back(bus.y_last);
        os.push_back(bus.y_src);  ot.push_back(c);
      end
      tick();
      if (hs0) begin void'(q0d.pop_front()); void'(q0l.pop_front()); end
      if (hs1) begin void'(q1d.pop_front()); void'(q1l.pop_front()); end
      if (q0d.size() == 0 && q1d.size() == 0 && !bus.y_valid) done = 1'b1;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %0b expected 00", bus.gnt); end
    checks++; if (bus.y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid: got %0b expected 0", bus.y_valid); end
    checks++; if (bus.y_data !== 8'h00) begin errors++; $display("FAIL reset_y_data: got %0h expected 00", bus.y_data); end
    checks++; if (bus.y_last !== 1'b0) begin errors++; $display("FAIL reset_y_last: got %0b expected 0", bus.y_last); end
    checks++; if (bus.y_src !== 1'b0) begin errors++; $display("FAIL reset_y_src: got %0b expected 0", bus.y_src); end
    checks++; if (bus.i0_ready !== 1'b0) begin errors++; $display("FAIL reset_i0_ready: got %0b expected 0", bus.i0_ready); end
    checks++; if (bus.i1_ready !== 1'b0) begin errors++; $display("FAIL reset_i1_ready: got %0b expected 0", bus.i1_ready); end
  endtask

  task automatic test_single_source();
    do_reset();
    bus.y_ready = 1'b1;
    bus.i0_valid = 1'b1; bus.i0_data = 8'h11; bus.i0_last = 1'b0;
    tick();
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL single_gnt: got %0b expected 01", bus.gnt); end
    checks++; if (bus.i0_ready !== 1'b1) begin errors++; $display("FAIL single_i0_ready: got %0b expected 1", bus.i0_ready); end
    checks++; if (bus.y_valid !== 1'b0) begin errors++; $display("FAIL single_y_valid_early: got %0b expected 0", bus.y_valid); end
    tick();
    checks++; if (bus.y_valid !== 1'b1 || bus.y_data !== 8'h11 || bus.y_last !== 1'b0 || bus.y_src !== 1'b0)
      begin errors++; $display("FAIL single_beat1: got v%0b d%0h l%0b s%0b expected v1 d11 l0 s0", bus.y_valid, bus.y_data, bus.y_last, bus.y_src); end
    bus.i0_data = 8'h22;
    tick();
    checks++; if (bus.y_valid !== 1'b1 || bus.y_data !== 8'h22 || bus.y_last !== 1'b0 || bus.y_src !== 1'b0)
      begin errors++; $display("FAIL single_beat2: got v%0b d%0h l%0b s%0b expected v1 d22 l0 s0", bus.y_valid, bus.y_data, bus.y_last, bus.y_src); end
    bus.i0_data = 8'h33; bus.i0_last = 1'b1;
    tick();
    checks++; if (bus.y_valid !== 1'b1 || bus.y_data !== 8'h33 || bus.y_last !== 1'b1 || bus.y_src !== 1'b0)
      begin errors++; $display("FAIL single_beat3: got v%0b d%0h l%0b s%0b expected v1 d33 l1 s0", bus.y_valid, bus.y_data, bus.y_last, bus.y_src); end
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL single_release_gnt: got %0b expected 00", bus.gnt); end
    idle_inputs();
    tick();
    checks++; if (bus.y_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %0b expected 0", bus.y_valid); end
  endtask

  task automatic test_contention();
    logic [7:0] ed[8] = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA2, 8'hA3, 8'hB2, 8'hB3};
    bit         es[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bit         el[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int         et[8] = '{2, 3, 5, 6, 8, 9, 11, 12};
    bit done;
    do_reset();
    q0d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3}; q0l = '{1'b0, 1'b1, 1'b0, 1'b1};
    q1d = '{8'hB0, 8'hB1, 8'hB2, 8'hB3}; q1l = '{1'b0, 1'b1, 1'b0, 1'b1};
    run(60, 0, 0, 0, 0, 0, done);
    checks++; if (!done) begin errors++; $display("FAIL contention_timeout: got 0 expected 1"); end
    checks++; if (od.size() != 8) begin errors++; $display("FAIL contention_count: got %0d expected 8", od.size()); end
    checks++; if (lg.size() < 5 || lg[1] !== 2'b01 || lg[4] !== 2'b10)
      begin errors++; $display("FAIL contention_gnt: got grant order wrong expected 01 then 10"); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= od.size() || od[i] !== ed[i] || os[i] !== es[i] || ol[i] !== el[i] || ot[i] != et[i]) begin
        errors++;
        if (i < od.size())
          $display("FAIL contention_beat%0d: got d%0h s%0b l%0b t%0d expected d%0h s%0b l%0b t%0d",
                   i, od[i], os[i], ol[i], ot[i], ed[i], es[i], el[i], et[i]);
        else
          $display("FAIL contention_beat%0d: got none expected d%0h", i, ed[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] ed[4] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    int         et[4] = '{2, 8, 9, 10};
    bit done;
    do_reset();
    q0d = '{8'hC0, 8'hC1, 8'hC2, 8'hC3}; q0l = '{1'b0, 1'b0, 1'b0, 1'b1};
    run(60, 3, 5, 0, 0, 0, done);
    checks++; if (!done) begin errors++; $display("FAIL bp_timeout: got 0 expected 1"); end
    for (int c = 3; c < 8; c++) begin
      checks++;
      if (c >= lyv.size() || lyv[c] !== 1'b1 || lyd[c] !== 8'hC1 || lyl[c] !== 1'b0 || lys[c] !== 1'b0 || lr0[c] !== 1'b0)
        begin errors++; $display("FAIL bp_hold_c%0d: got output not held or ready high expected C1 held, i0_ready 0", c); end
    end
    checks++; if (lr0.size() < 9 || lr0[8] !== 1'b1) begin errors++; $display("FAIL bp_resume_ready: got 0 expected 1"); end
    checks++; if (od.size() != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", od.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= od.size() || od[i] !== ed[i] || ol[i] !== (i == 3) || ot[i] != et[i])
        begin errors++; $display("FAIL bp_beat%0d: got wrong or missing beat expected d%0h t%0d", i, ed[i], et[i]); end
    end
  endtask

  task automatic test_source_stall();
    logic [7:0] ed[5] = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hE0};
    bit         es[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int         et[5] = '{2, 3, 7, 8, 10};
    bit done;
    do_reset();
    q1d = '{8'hD0, 8'hD1, 8'hD2, 8'hD3}; q1l = '{1'b0, 1'b0, 1'b0, 1'b1};
    q0d = '{8'hE0}; q0l = '{1'b1};
    run(60, 0, 0, 3, 3, 1, done);
    checks++; if (!done) begin errors++; $display("FAIL stall_timeout: got 0 expected 1"); end
    for (int c = 3; c < 6; c++) begin
      checks++;
      if (c >= lg.size() || lg[c] !== 2'b10 || lr0[c] !== 1'b0)
        begin errors++; $display("FAIL stall_hold_c%0d: got grant moved or i0_ready high expected gnt 10, i0_ready 0", c); end
    end
    checks++; if (lg.size() < 10 || lg[8] !== 2'b00 || lg[9] !== 2'b01)
      begin errors++; $display("FAIL stall_handover: got wrong grant after release expected 00 then 01"); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= od.size() || od[i] !== ed[i] || os[i] !== es[i] || ot[i] != et[i])
        begin errors++; $display("FAIL stall_beat%0d: got wrong or missing beat expected d%0h s%0b t%0d", i, ed[i], es[i], et[i]); end
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    bus.y_ready = 1'b1;
    bus.i0_valid = 1'b1; bus.i0_data = 8'hF0; bus.i0_last = 1'b0;
    tick();
    tick();
    bus.i0_data = 8'hF1;
    rst = 1'b1;
    tick();
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL rstmid_gnt: got %0b expected 00", bus.gnt); end
    checks++; if (bus.y_valid !== 1'b0 || bus.y_data !== 8'h00 || bus.y_last !== 1'b0 || bus.y_src !== 1'b0)
      begin errors++; $display("FAIL rstmid_y: got v%0b d%0h l%0b s%0b expected all 0", bus.y_valid, bus.y_data, bus.y_last, bus.y_src); end
    checks++; if (bus.i0_ready !== 1'b0 || bus.i1_ready !== 1'b0)
      begin errors++; $display("FAIL rstmid_ready: got %0b%0b expected 00", bus.i1_ready, bus.i0_ready); end
    rst = 1'b0;
    idle_inputs();
    bus.i1_valid = 1'b1; bus.i1_data = 8'h5A; bus.i1_last = 1'b1;
    tick();
    checks++; if (bus.gnt !== 2'b10 || bus.i1_ready !== 1'b1)
      begin errors++; $display("FAIL rstmid_regrant: got gnt %0b rdy %0b expected 10 1", bus.gnt, bus.i1_ready); end
    tick();
    idle_inputs();
    checks++; if (bus.y_valid !== 1'b1 || bus.y_data !== 8'h5A || bus.y_src !== 1'b1 || bus.y_last !== 1'b1)
      begin errors++; $display("FAIL rstmid_beat: got v%0b d%0h s%0b l%0b expected v1 d5a s1 l1", bus.y_valid, bus.y_data, bus.y_src, bus.y_last); end
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL rstmid_release: got %0b expected 00", bus.gnt); end
  endtask

`ifdef MUX2X1_ARB_BURST_LIMIT_EN
  task automatic test_burst_limit();
    logic [7:0] ed[12] = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h70, 8'h71, 8'h72, 8'h73,
                           8'h64, 8'h65, 8'h74, 8'h75};
    bit done;
    do_reset();
    q0d = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    q0l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    q1d = '{8'h70, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75};
    q1l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    run(80, 0, 0, 0, 0, 0, done);
    checks++; if (!done) begin errors++; $display("FAIL burst_timeout: got 0 expected 1"); end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (i >= od.size() || od[i] !== ed[i])
        begin errors++; $display("FAIL burst_beat%0d: got wrong or missing beat expected d%0h", i, ed[i]); end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    bus.y_ready = 1'b0;
    test_reset();
    test_single_source();
    test_contention();
    test_backpressure();
    test_source_stall();
    test_reset_mid_packet();
`ifdef MUX2X1_ARB_BURST_LIMIT_EN
    test_burst_limit();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
